// File: rtl/mant_mult_norm.sv
// mant_mult_norm -- iterative shift-add mantissa multiplier with normaliser.
//
// Multiplies two MW-bit mantissas (hidden bit included) one partial product
// per clock, LSB-first, then normalises the 2*MW-bit product into the pre-round
// word {frac[MW-2:0], b1, b0, sticky} and computes the adjusted exponent.
// A cleared hidden bit on either operand flushes the result to zero.
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   reset    in   synchronous active-high reset, highest priority
//   start    in   operation request, sampled only while idle
//   mant_a   in   [MW-1:0]  operand A mantissa (bit MW-1 = hidden bit)
//   mant_b   in   [MW-1:0]  operand B mantissa
//   exp_a    in   [EW-1:0]  operand A biased exponent
//   exp_b    in   [EW-1:0]  operand B biased exponent
//   busy     out  high while an operation is in progress
//   done     out  one-cycle pulse, result valid
//   mant_out out  [OUT_W-1:0] pre-round word {frac, b1, b0, sticky}
//   exp_out  out  [EW+1:0] two's-complement adjusted exponent
//   zero_out out  result is exactly zero
module mant_mult_norm #(
   parameter int MW    = 24,
   parameter int EW    = 8,
   parameter int BIAS  = 127,
   parameter int OUT_W = 26
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MW-1:0]      mant_a,
   input  logic [MW-1:0]      mant_b,
   input  logic [EW-1:0]      exp_a,
   input  logic [EW-1:0]      exp_b,
   output logic               busy,
   output logic               done,
   output logic [OUT_W-1:0]   mant_out,
   output logic [EW+1:0]      exp_out,
   output logic               zero_out
);

   localparam int                CW       = $clog2(MW);
   localparam logic [CW-1:0]     LAST_CNT = CW'(MW - 1);
   localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
   localparam logic [EW+1:0]     BIAS_W   = (EW + 2)'(BIAS);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_NORM = 2'b10
   } state_t;

   state_t              state_r, state_nx;
   logic [CW-1:0]       cnt_r, cnt_nx;
   logic [2*MW-1:0]     prod_r, prod_nx;
   logic [MW-1:0]       ma_r, mb_r;
   logic [EW-1:0]       ea_r, eb_r;
   logic                load_s;
   logic                out_en_s;

   logic [2*MW-1:0]     pp_s;
   logic                norm_s;
   logic [MW-2:0]       frac_s;
   logic [1:0]          ext_s;
   logic                sticky_s;
   logic                zero_s;
   logic [OUT_W-1:0]    mant_nx_s;
   logic [EW+1:0]       exp_nx_s;

   logic                busy_r, done_r, zero_r;
   logic [OUT_W-1:0]    mant_r;
   logic [EW+1:0]       exp_r;

   // Partial product for the current multiplier bit.
   assign pp_s = {{MW{1'b0}}, ma_r} << cnt_r;

   // Next-state, counter and product accumulation.
   always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      prod_nx  = prod_r;
      load_s   = 1'b0;
      out_en_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nx = S_MUL;
               cnt_nx   = {CW{1'b0}};
               prod_nx  = {(2*MW){1'b0}};
               load_s   = 1'b1;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_MUL: begin
            if (mb_r[cnt_r]) begin
               prod_nx = prod_r + pp_s;
            end else begin
               prod_nx = prod_r;
            end
            cnt_nx = cnt_r + CNT_ONE;
            if (cnt_r == LAST_CNT) begin
               state_nx = S_NORM;
            end else begin
               state_nx = S_MUL;
            end
         end
         S_NORM: begin
            out_en_s = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Normalise the finished product: a leading one in the top bit means the
   // significand is in [2,4) and the window moves up by one.
   always_comb begin
      norm_s   = prod_r[2*MW-1];
      frac_s   = {(MW-1){1'b0}};
      ext_s    = 2'b00;
      sticky_s = 1'b0;
      if (norm_s) begin
         frac_s   = prod_r[2*MW-2:MW];
         ext_s    = prod_r[MW-1:MW-2];
         sticky_s = |prod_r[MW-3:0];
      end else begin
         frac_s   = prod_r[2*MW-3:MW-1];
         ext_s    = prod_r[MW-2:MW-3];
         sticky_s = |prod_r[MW-4:0];
      end
   end

   assign zero_s    = ~(ma_r[MW-1] & mb_r[MW-1]);
   assign mant_nx_s = {frac_s, ext_s, sticky_s};
   assign exp_nx_s  = {2'b00, ea_r} + {2'b00, eb_r} - BIAS_W
                    + {{(EW+1){1'b0}}, norm_s};

   // FSM state, counter, product and latched operands.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         cnt_r   <= {CW{1'b0}};
         prod_r  <= {(2*MW){1'b0}};
         ma_r    <= {MW{1'b0}};
         mb_r    <= {MW{1'b0}};
         ea_r    <= {EW{1'b0}};
         eb_r    <= {EW{1'b0}};
      end else begin
         state_r <= state_nx;
         cnt_r   <= cnt_nx;
         prod_r  <= prod_nx;
         if (load_s) begin
            ma_r <= mant_a;
            mb_r <= mant_b;
            ea_r <= exp_a;
            eb_r <= exp_b;
         end else begin
            ma_r <= ma_r;
            mb_r <= mb_r;
            ea_r <= ea_r;
            eb_r <= eb_r;
         end
      end
   end

   // Registered outputs; results hold until the next normalise cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         mant_r <= {OUT_W{1'b0}};
         exp_r  <= {(EW+2){1'b0}};
         zero_r <= 1'b0;
      end else begin
         busy_r <= (state_nx != S_IDLE);
         done_r <= out_en_s;
         if (out_en_s) begin
            if (zero_s) begin
               mant_r <= {OUT_W{1'b0}};
               exp_r  <= {(EW+2){1'b0}};
               zero_r <= 1'b1;
            end else begin
               mant_r <= mant_nx_s;
               exp_r  <= exp_nx_s;
               zero_r <= 1'b0;
            end
         end else begin
            mant_r <= mant_r;
            exp_r  <= exp_r;
            zero_r <= zero_r;
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign mant_out = mant_r;
   assign exp_out  = exp_r;
   assign zero_out = zero_r;

endmodule
